csa_mult_pipe: RTL and testbench



---
 rtl/csa_mult_pipe.sv | 127 ++++++++++++
 tb/tb_csa_mult_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_mult_pipe.sv
// rtl/csa_mult_pipe.sv - pipelined carry-save array multiplier, per-transaction signed/unsigned
// Row stages accumulate partial products in (sum, carry) form; the final carry-propagate add is split over two registers.
module csa_mult_pipe #(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod
);

    localparam int N  = WIDTH / ROWS_PER_STAGE;
    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    if (WIDTH < 2 || ROWS_PER_STAGE < 1 || (WIDTH % ROWS_PER_STAGE) != 0) begin : g_bad_params
        $error("csa_mult_pipe: WIDTH must be >= 2 and divisible by ROWS_PER_STAGE");
    end

    logic [N-1:0][WIDTH-1:0] a_r;
    logic [N-1:0][WIDTH-1:0] b_r;
    logic [N-1:0]            sgn_r;
    logic [N:0]              vld_r;
    logic [N:0][PW-1:0]      sum_r;
    logic [N:0][PW-1:0]      car_r;
    logic [N:1][PW-1:0]      nsum;
    logic [N:1][PW-1:0]      ncar;

    logic [WIDTH-1:0]        lo_r;
    logic                    lo_c_r;
    logic [WIDTH-1:0]        hi_s_r;
    logic [WIDTH-1:0]        hi_c_r;
    logic                    cpa_vld_r;
    logic [WIDTH:0]          lo_add;
    logic                    stall;

    // Baugh-Wooley: invert a_msb&b_j and a_i&b_msb except the msb*msb term.
    function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] a, input logic b_bit,
                                             input int j, input logic sgn);
        logic [PW-1:0] r;
        logic          t;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t = a[i] & b_bit;
            if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1)))
                t = ~t;
            r[i + j] = t;
        end
        return r;
    endfunction

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_comb begin : p_rows
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [PW-1:0] pp;
        logic [PW-1:0] maj;
        int            j;
        s    = '0;
        c    = '0;
        pp   = '0;
        maj  = '0;
        j    = 0;
        nsum = '0;
        ncar = '0;
        for (int k = 1; k <= N; k++) begin
            s = sum_r[k-1];
            c = car_r[k-1];
            for (int r = 0; r < ROWS_PER_STAGE; r++) begin
                j   = (k - 1) * ROWS_PER_STAGE + r;
                pp  = pp_row(a_r[k-1], b_r[k-1][j], j, sgn_r[k-1]);
                maj = (s & c) | (s & pp) | (c & pp);
                s   = s ^ c ^ pp;
                c   = maj << 1;
            end
            nsum[k] = s;
            ncar[k] = c;
        end
    end

    assign lo_add = {1'b0, sum_r[N][WIDTH-1:0]} + {1'b0, car_r[N][WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r     <= '0;
            cpa_vld_r <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
        end else if (!stall) begin
            vld_r[0] <= in_valid && in_ready;
            a_r[0]   <= in_a;
            b_r[0]   <= in_b;
            sgn_r[0] <= in_signed;
            sum_r[0] <= '0;
            // The signed-mode constants ride in on the initial carry vector.
            car_r[0] <= in_signed ? BW_CONST : '0;
            for (int k = 1; k < N; k++) begin
                a_r[k]   <= a_r[k-1];
                b_r[k]   <= b_r[k-1];
                sgn_r[k] <= sgn_r[k-1];
            end
            for (int k = 1; k <= N; k++) begin
                vld_r[k] <= vld_r[k-1];
                sum_r[k] <= nsum[k];
                car_r[k] <= ncar[k];
            end
            cpa_vld_r <= vld_r[N];
            lo_r      <= lo_add[WIDTH-1:0];
            lo_c_r    <= lo_add[WIDTH];
            hi_s_r    <= sum_r[N][PW-1:WIDTH];
            hi_c_r    <= car_r[N][PW-1:WIDTH];
            out_valid <= cpa_vld_r;
            if (cpa_vld_r)
                out_prod <= {hi_s_r + hi_c_r + WIDTH'(lo_c_r), lo_r};
        end
    end

endmodule

// File: tb/tb_csa_mult_pipe.sv
// tb/tb_csa_mult_pipe.sv - scoreboard bench for csa_mult_pipe at default and swept parameters
module tb_csa_mult_pipe;

    localparam int LAT = 6;

    typedef struct {
        logic [31:0] prod;
        int          issue;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_prod;
    logic [15:0] exp_in = '0;
    bit          lat_chk = 1'b1;
    int          stall_cnt = 0;
    bit          seen_m = 1'b0;

    logic        sw_valid = 1'b0, sw_s4 = 1'b0, sw_s16 = 1'b0;
    logic [3:0]  sw_a4 = '0, sw_b4 = '0;
    logic [15:0] sw_a16 = '0, sw_b16 = '0;
    logic        rdy4, ov4, rdy16, ov16;
    logic [7:0]  prod4;
    logic [31:0] prod16;

    exp_t q_m[$];
    exp_t q4[$];
    exp_t q16[$];

    logic [7:0]  ca [6] = '{8'hFF, 8'h00, 8'h01, 8'h80, 8'hFF, 8'h80};
    logic [7:0]  cb [6] = '{8'hFF, 8'hC8, 8'hAD, 8'h80, 8'h7F, 8'h7F};
    logic        cs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] ce [6] = '{16'hFE01, 16'h0000, 16'h00AD, 16'h4000, 16'hFF81, 16'hC080};

    csa_mult_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod)
    );

    csa_mult_pipe #(.WIDTH(4), .ROWS_PER_STAGE(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy4), .in_a(sw_a4), .in_b(sw_b4),
        .in_signed(sw_s4), .out_valid(ov4), .out_ready(1'b1), .out_prod(prod4)
    );

    csa_mult_pipe #(.WIDTH(16), .ROWS_PER_STAGE(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy16), .in_a(sw_a16), .in_b(sw_b16),
        .in_signed(sw_s16), .out_valid(ov16), .out_ready(1'b1), .out_prod(prod16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q_m.delete();
            seen_m = 1'b0;
        end else begin
            if (in_valid && in_ready) q_m.push_back('{32'(exp_in), cyc + 1, lat_chk});
            if (!in_ready) stall_cnt++;
            if (out_valid) begin
                if (q_m.size() == 0) check("main spurious out_valid", 32'(out_valid), 32'd0);
                else begin
                    if (!seen_m && q_m[0].chk) check("main latency", 32'(cyc - q_m[0].issue), LAT);
                    seen_m = 1'b1;
                    check("main out_prod", 32'(out_prod), q_m[0].prod);
                    if (out_ready) begin
                        void'(q_m.pop_front());
                        seen_m = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) q4.delete();
        else begin
            if (sw_valid && rdy4) q4.push_back('{ref_mul(4, 16'(sw_a4), 16'(sw_b4), sw_s4), cyc + 1, 1'b1});
            if (ov4) begin
                if (q4.size() == 0) check("w4 spurious out_valid", 32'(ov4), 32'd0);
                else begin
                    check("w4 latency", 32'(cyc - q4[0].issue), 4 / 1 + 2);
                    check("w4 out_prod", 32'(prod4), q4[0].prod);
                    void'(q4.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) q16.delete();
        else begin
            if (sw_valid && rdy16) q16.push_back('{ref_mul(16, sw_a16, sw_b16, sw_s16), cyc + 1, 1'b1});
            if (ov16) begin
                if (q16.size() == 0) check("w16 spurious out_valid", 32'(ov16), 32'd0);
                else begin
                    check("w16 latency", 32'(cyc - q16[0].issue), 16 / 4 + 2);
                    check("w16 out_prod", prod16, q16[0].prod);
                    void'(q16.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
        bit acc, done;
        done = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; exp_in = e;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) check("issue accept timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            if (q_m.size() == 0 && q4.size() == 0 && q16.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain main", 32'(q_m.size()), 32'd0);
        check("drain w4", 32'(q4.size()), 32'd0);
        check("drain w16", 32'(q16.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_prod", 32'(out_prod), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            issue(ca[i], cb[i], cs[i], ce[i]);
            repeat (8) begin @(posedge clk); #1; end
        end
        drain();

        fork
            for (int i = 0; i < 10; i++)
                issue(8'hFF, 8'hFF, (i % 2) == 0, ((i % 2) == 0) ? 16'h0001 : 16'hFE01);
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 20) begin @(negedge clk); t++; end
                for (int i = 0; i < 10; i++) begin
                    check("stream out_valid continuous", 32'(out_valid), 32'd1);
                    @(negedge clk);
                end
            end
        join
        drain();

        lat_chk = 1'b0;
        stall_cnt = 0;
        fork
            begin
                issue(8'd3, 8'd5, 1'b0, 16'h000F);
                issue(8'd7, 8'd9, 1'b0, 16'h003F);
                issue(8'd11, 8'd13, 1'b0, 16'h008F);
                issue(8'd15, 8'd17, 1'b0, 16'h00FF);
                issue(8'd19, 8'd21, 1'b0, 16'h018F);
                issue(8'd23, 8'd25, 1'b0, 16'h023F);
                issue(8'd27, 8'd29, 1'b0, 16'h030F);
                issue(8'd31, 8'd33, 1'b0, 16'h03FF);
            end
            begin
                int t;
                t = 0;
                do begin @(posedge clk); #1; t++; end while (!out_valid && t < 30);
                out_ready = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();
        check("backpressure in_ready low cycles", 32'(stall_cnt), 32'd3);
        lat_chk = 1'b1;

        issue(8'h11, 8'h22, 1'b0, 16'h0242);
        issue(8'h21, 8'h03, 1'b0, 16'h0063);
        issue(8'h0F, 8'h0F, 1'b0, 16'h00E1);
        issue(8'h10, 8'h10, 1'b0, 16'h0100);
        rst = 1'b1;
        in_valid = 1'b1; in_a = 8'h55; in_b = 8'h66; in_signed = 1'b0; exp_in = 16'h21DE;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post-reset out_valid", 32'(out_valid), 32'd0);
        check("post-reset out_prod", 32'(out_prod), 32'd0);
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        issue(8'h12, 8'h34, 1'b0, 16'h03A8);
        drain();
        repeat (10) begin @(posedge clk); #1; end

        for (int i = 0; i < 24; i++) begin
            sw_valid = 1'b1;
            sw_s4  = 1'($urandom_range(0, 1));
            sw_s16 = 1'($urandom_range(0, 1));
            sw_a4  = (i == 0) ? 4'h8 : 4'($urandom);
            sw_b4  = (i == 0) ? 4'h8 : 4'($urandom);
            sw_a16 = (i == 1) ? 16'h8000 : 16'($urandom);
            sw_b16 = (i == 1) ? 16'hFFFF : 16'($urandom);
            @(posedge clk); #1;
        end
        sw_valid = 1'b0;
        drain();
        repeat (5) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
